count_tx_framer: RTL

Transmit-side companion to the 16-bit SPI command controller. When the controller raises READ_DATA, this block snapshots the latest 32-bit photon count and presents it as a 4-word frame on the 16-bit tx register of the SPI slave: header, count high, count low, XOR checksum. It advances one word per completed SPI word transfer, so the host drains one frame per read request.

---
 rtl/count_tx_framer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/count_tx_framer.sv
// rtl/count_tx_framer.sv - photon-count snapshot framer for the 16-bit SPI slave tx register
//
// Snapshots the latest 32-bit photon count and, on each rising edge of
// READ_DATA, presents a 4-word frame on tx: header, count high, count low,
// XOR checksum. Advances one word per SPI_DONE strobe.
//
// Ports:
//   CLK          in   system clock, rising-edge active
//   RST_N        in   asynchronous active-low reset
//   READ_DATA    in   frame request level; rising edge starts, low aborts
//   COUNT_VALID  in   one-cycle strobe qualifying COUNT
//   COUNT[31:0]  in   photon count value
//   SPI_DONE     in   one-cycle strobe: current tx word has been shifted out
//   tx[15:0]     out  word for the next SPI transfer (0 when idle)
//   TX_READY     out  tx holds a valid frame word
//   BUSY         out  frame in progress
//   FRAME_DONE   out  one-cycle pulse after the checksum word is consumed
module count_tx_framer #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        READ_DATA,
  input  logic        COUNT_VALID,
  input  logic [31:0] COUNT,
  input  logic        SPI_DONE,
  output logic [15:0] tx,
  output logic        TX_READY,
  output logic        BUSY,
  output logic        FRAME_DONE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rd_q;
  logic [31:0] r_snap;
  logic        r_fresh;
  logic [6:0]  r_seq;
  logic [31:0] r_cnt;
  logic [15:0] r_hdr;

  logic        w_start;
  logic        w_launch;
  logic        w_fresh_eff;
  logic [31:0] w_cnt_src;
  logic [15:0] w_hdr_word;
  logic [15:0] w_tx_nxt;
  logic        w_done_nxt;

  assign w_start = READ_DATA & ~r_rd_q;

  // A count arriving in the same cycle as the frame start is the freshest
  // value available, so it bypasses the snapshot register.
  assign w_cnt_src   = COUNT_VALID ? COUNT : r_snap;
  assign w_fresh_eff = COUNT_VALID | r_fresh;
  assign w_hdr_word  = {HEADER, r_seq, w_fresh_eff};

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = tx;
    w_done_nxt  = 1'b0;
    w_launch    = 1'b0;
    if (r_state == S_IDLE) begin
      w_tx_nxt = 16'h0000;
      if (w_start) begin
        w_state_nxt = S_HDR;
        w_tx_nxt    = w_hdr_word;
        w_launch    = 1'b1;
      end
    end else if (!READ_DATA) begin
      // Abort has priority over a coincident SPI_DONE.
      w_state_nxt = S_IDLE;
      w_tx_nxt    = 16'h0000;
    end else if (SPI_DONE) begin
      case (r_state)
        S_HDR: begin
          w_state_nxt = S_HI;
          w_tx_nxt    = r_cnt[31:16];
        end
        S_HI: begin
          w_state_nxt = S_LO;
          w_tx_nxt    = r_cnt[15:0];
        end
        S_LO: begin
          w_state_nxt = S_CHK;
          w_tx_nxt    = r_hdr ^ r_cnt[31:16] ^ r_cnt[15:0];
        end
        S_CHK: begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 16'h0000;
          w_done_nxt  = 1'b1;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 16'h0000;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_rd_q     <= 1'b0;
      r_snap     <= 32'h0;
      r_fresh    <= 1'b0;
      r_seq      <= 7'd0;
      r_cnt      <= 32'h0;
      r_hdr      <= 16'h0;
      tx         <= 16'h0000;
      TX_READY   <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rd_q  <= READ_DATA;
      if (COUNT_VALID) begin
        r_snap <= COUNT;
      end
      // Frame start consumes freshness even if a count lands in the same
      // cycle; that count is already reported via the header's fresh bit.
      if (w_launch) begin
        r_fresh <= 1'b0;
        r_seq   <= r_seq + 7'd1;
        r_cnt   <= w_cnt_src;
        r_hdr   <= w_hdr_word;
      end else if (COUNT_VALID) begin
        r_fresh <= 1'b1;
      end
      tx         <= w_tx_nxt;
      TX_READY   <= (w_state_nxt != S_IDLE);
      BUSY       <= (w_state_nxt != S_IDLE);
      FRAME_DONE <= w_done_nxt;
    end
  end

endmodule
